// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, WIDTH data bits LSB first, optional even
// parity, stop bit. Each bit is held for DIV clock cycles.
module serial_tx #(
  parameter int WIDTH  = 8,
  parameter int DIV    = 4,
  parameter int PARITY = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             tx,
  output logic             done
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic          DONE_ON_ENTRY = (DIV == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             par_bit;
  logic [DW-1:0]    div;
  logic [CW-1:0]    cnt;
  logic             bit_end;

  assign sr_next = sr >> 1;
  assign bit_end = (div == DIV_LAST);

  // Outputs are set one edge ahead from the next-state decision so tx never glitches.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      tx      <= 1'b1;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      sr      <= '0;
      par_bit <= 1'b0;
      cnt     <= '0;
      div     <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (load) begin
          sr      <= data;
          par_bit <= ^data;
          div     <= '0;
          state   <= START;
          tx      <= 1'b0;
          ready   <= 1'b0;
          busy    <= 1'b1;
        end
      end else if (bit_end) begin
        div <= '0;
        case (state)
          START: begin
            state <= DATA;
            cnt   <= '0;
            tx    <= sr[0];
          end
          DATA: begin
            sr  <= sr_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              if (PARITY != 0) begin
                state <= PAR;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
                done  <= DONE_ON_ENTRY;
              end
            end else begin
              tx <= sr_next[0];
            end
          end
          PAR: begin
            state <= STOP;
            tx    <= 1'b1;
            done  <= DONE_ON_ENTRY;
          end
          default: begin
            state <= IDLE;
            tx    <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end else begin
        div  <= div + 1'b1;
        // done lands on the final cycle of the stop bit.
        done <= (state == STOP) && ((div + 1'b1) == DIV_LAST);
      end
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboarded bench for serial_tx in three configurations: (8,4,parity),
// (8,4,no parity) and (4,1,parity).
module tb_serial_tx;

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  logic       clk, clr;
  logic [7:0] data0, data1;
  logic [3:0] data2;
  logic       load0, load1, load2;
  logic       ready0, busy0, tx0, done0;
  logic       ready1, busy1, tx1, done1;
  logic       ready2, busy2, tx2, done2;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  frame_t      q0[$], q1[$], q2[$];
  logic [63:0] capt[3];
  int          ccnt[3];
  bit          rdy_pend[3];

  serial_tx #(.WIDTH(8), .DIV(4), .PARITY(1)) u0 (
    .clk(clk), .clr(clr), .data(data0), .load(load0),
    .ready(ready0), .busy(busy0), .tx(tx0), .done(done0));
  serial_tx #(.WIDTH(8), .DIV(4), .PARITY(0)) u1 (
    .clk(clk), .clr(clr), .data(data1), .load(load1),
    .ready(ready1), .busy(busy1), .tx(tx1), .done(done1));
  serial_tx #(.WIDTH(4), .DIV(1), .PARITY(1)) u2 (
    .clk(clk), .clr(clr), .data(data2), .load(load2),
    .ready(ready2), .busy(busy2), .tx(tx2), .done(done2));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push(input int id, input logic [15:0] bits, input int n);
    frame_t f;
    f.bits = bits;
    f.n    = n;
    case (id)
      0:       q0.push_back(f);
      1:       q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endfunction

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic frame_t qpop(input int id);
    case (id)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic logic rdy(input int id);
    case (id)
      0:       return ready0;
      1:       return ready1;
      default: return ready2;
    endcase
  endfunction

  task automatic mon(input int id, input logic b, input logic t, input logic d,
                     input logic r, input int dv);
    frame_t      e;
    logic [63:0] s;
    if (clr) begin
      ccnt[id] = 0;
      capt[id] = '0;
      rdy_pend[id] = 0;
      return;
    end
    if (rdy_pend[id]) begin
      chk($sformatf("ready_after_done%0d", id), r, 1);
      rdy_pend[id] = 0;
    end
    if (b) begin
      if (ccnt[id] < 64) capt[id][ccnt[id]] = t;
      ccnt[id]++;
    end else begin
      chk($sformatf("idle_tx_high%0d", id), t, 1);
    end
    if (d) begin
      chk($sformatf("done_ready_excl%0d", id), r, 0);
      if (qsize(id) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done%0d: got done=1 expected no frame pending", id);
      end else begin
        e = qpop(id);
        s = '0;
        for (int k = 0; k < e.n * dv; k++) s[k] = e.bits[k / dv];
        chk($sformatf("frame_len%0d", id), ccnt[id], e.n * dv);
        chk($sformatf("frame_bits%0d", id), capt[id], s);
      end
      ccnt[id] = 0;
      capt[id] = '0;
      rdy_pend[id] = 1;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, busy0, tx0, done0, ready0, 4);
      mon(1, busy1, tx1, done1, ready1, 4);
      mon(2, busy2, tx2, done2, ready2, 1);
    end
  end

  task automatic wait_rdy(input int id);
    int i = 0;
    while (!rdy(id) && i < 500) begin
      @(negedge clk);
      i++;
    end
    if (!rdy(id)) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout%0d: got ready=0 expected ready=1 within 500 cycles", id);
    end
  endtask

  task automatic send0(input logic [7:0] d, input logic [15:0] bits, input int n);
    wait_rdy(0);
    data0 = d;
    load0 = 1;
    push(0, bits, n);
    @(negedge clk);
    load0 = 0;
    data0 = ~d;
  endtask

  task automatic send1(input logic [7:0] d, input logic [15:0] bits, input int n);
    wait_rdy(1);
    data1 = d;
    load1 = 1;
    push(1, bits, n);
    @(negedge clk);
    load1 = 0;
    data1 = ~d;
  endtask

  task automatic send2(input logic [3:0] d, input logic [15:0] bits, input int n);
    wait_rdy(2);
    data2 = d;
    load2 = 1;
    push(2, bits, n);
    @(negedge clk);
    load2 = 0;
    data2 = ~d;
  endtask

  initial begin
    int i;
    for (int k = 0; k < 3; k++) begin
      capt[k] = '0;
      ccnt[k] = 0;
      rdy_pend[k] = 0;
    end
    clr = 0;
    data0 = 'x; data1 = 'x; data2 = 'x;
    load0 = 'x; load1 = 'x; load2 = 'x;

    // Asynchronous reset mid-cycle with unknown inputs.
    #3 clr = 1;
    #1;
    chk("reset_tx", tx0, 1);
    chk("reset_ready", ready0, 1);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    @(negedge clk);
    load0 = 0; load1 = 0; load2 = 0;
    data0 = 0; data1 = 0; data2 = 0;
    @(negedge clk);
    clr = 0;
    #1 mon_en = 1;
    repeat (20) @(negedge clk);
    chk("idle_20_tx", tx0, 1);

    // Frame bit vectors, LSB = start bit, then data, [parity], stop.
    send0(8'hA5, 16'h054A, 11);
    send0(8'h07, 16'h060E, 11);
    send1(8'h07, 16'h020E, 10);
    send1(8'hA5, 16'h034A, 10);

    // Load held through a frame; data changes mid-frame; second frame back-to-back.
    wait_rdy(0);
    wait_rdy(1);
    data0 = 8'h3C;
    load0 = 1;
    push(0, 16'h0478, 11);
    push(0, 16'h05FE, 11);
    repeat (5) @(negedge clk);
    data0 = 8'hFF;
    wait_rdy(0);
    @(negedge clk);
    chk("b2b_busy", busy0, 1);
    chk("b2b_start_tx", tx0, 0);
    load0 = 0;
    @(negedge clk);
    wait_rdy(0);

    // Abort during data bit 3 of 0x55 (that bit is 0 on the line).
    data0 = 8'h55;
    load0 = 1;
    @(negedge clk);
    load0 = 0;
    repeat (17) @(negedge clk);
    chk("abort_pre_tx", tx0, 0);
    #2 clr = 1;
    #1;
    chk("abort_tx", tx0, 1);
    chk("abort_ready", ready0, 1);
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    @(negedge clk);
    #1 clr = 0;
    repeat (30) @(negedge clk);
    chk("abort_no_resume", busy0, 0);
    send0(8'h81, 16'h0502, 11);

    // Single-cycle bits, 4-bit words.
    send2(4'hE, 16'h007C, 7);
    send2(4'h5, 16'h004A, 7);

    i = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && i < 500) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    chk("queues_drained", q0.size() + q1.size() + q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
